// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between an I-cache and a D-cache.
// One transfer at a time; the granted request's command, address and data are latched at grant.
module cache_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e            state_q;
    logic              last_d_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              read_q;
    logic              write_q;

    logic i_req_c;
    logic d_req_c;
    logic grant_d_c;
    logic grant_i_c;

    // On a tie the requester that was not served last wins.
    assign i_req_c   = icache_read;
    assign d_req_c   = dcache_read | dcache_write;
    assign grant_d_c = d_req_c & (~i_req_c | ~last_d_q);
    assign grant_i_c = i_req_c & ~grant_d_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d_c) begin
                        // Write wins if both D commands are raised together.
                        state_q  <= SERVE_D;
                        last_d_q <= 1'b1;
                        addr_q   <= dcache_address;
                        wdata_q  <= dcache_wdata;
                        write_q  <= dcache_write;
                        read_q   <= ~dcache_write;
                    end else if (grant_i_c) begin
                        state_q  <= SERVE_I;
                        last_d_q <= 1'b0;
                        addr_q   <= icache_address;
                        write_q  <= 1'b0;
                        read_q   <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Completion is forwarded only to the owner of the current transfer.
    assign icache_resp  = (state_q == SERVE_I) & pmem_resp;
    assign dcache_resp  = (state_q == SERVE_D) & pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level round-robin model.
module tb_cache_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk;
    logic              rst;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic              icache_resp;
    logic [LINE_W-1:0] icache_rdata;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic              dcache_resp;
    logic [LINE_W-1:0] dcache_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: who was served last (1 = D) and the last latched address/data.
    logic              m_last_d;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_last_d = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
    endtask

    task automatic clear_inputs();
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    // Presents a request set in IDLE, holds pmem busy for waitc cycles while the
    // requester inputs churn, then completes with rdata rd. Returns the grantee.
    task automatic run_txn(input logic ir, input logic dr, input logic dw,
                           input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                           input logic [LINE_W-1:0] wd, input int unsigned waitc,
                           input logic [LINE_W-1:0] rd, output logic got_d);
        logic exp_rd, exp_wr;
        got_d = (dr | dw) & (!ir | !m_last_d);
        m_last_d = got_d;
        m_addr   = got_d ? da : ia;
        if (got_d) m_wdata = wd;
        exp_wr = got_d & dw;
        exp_rd = !exp_wr;

        @(negedge clk);
        icache_read = ir; icache_address = ia;
        dcache_read = dr; dcache_write = dw; dcache_address = da; dcache_wdata = wd;
        @(negedge clk);
        n_cmp++;
        if (pmem_read !== exp_rd || pmem_write !== exp_wr || pmem_address !== m_addr) begin
            n_fail++;
            $display("FAIL grant_cmd: got rd=%b wr=%b addr=%h, want rd=%b wr=%b addr=%h",
                     pmem_read, pmem_write, pmem_address, exp_rd, exp_wr, m_addr);
        end
        if (got_d) begin
            n_cmp++;
            if (pmem_wdata !== m_wdata) begin
                n_fail++;
                $display("FAIL grant_wdata: got %h want %h", pmem_wdata, m_wdata);
            end
        end
        for (int c = 0; c < int'(waitc); c++) begin
            icache_read = 1'($urandom); icache_address = $urandom;
            dcache_read = 1'($urandom); dcache_write = 1'($urandom);
            dcache_address = $urandom; dcache_wdata = rand_line();
            @(negedge clk);
            n_cmp++;
            if (pmem_read !== exp_rd || pmem_write !== exp_wr || pmem_address !== m_addr ||
                pmem_wdata !== m_wdata || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL serve_hold: got rd=%b wr=%b addr=%h iresp=%b dresp=%b, want rd=%b wr=%b addr=%h resp=0",
                         pmem_read, pmem_write, pmem_address, icache_resp, dcache_resp,
                         exp_rd, exp_wr, m_addr);
            end
        end
        pmem_resp = 1'b1; pmem_rdata = rd;
        #1;
        n_cmp++;
        if (icache_resp !== !got_d || dcache_resp !== got_d ||
            icache_rdata !== rd || dcache_rdata !== rd) begin
            n_fail++;
            $display("FAIL complete: got iresp=%b dresp=%b irdata=%h, want iresp=%b dresp=%b rdata=%h",
                     icache_resp, dcache_resp, icache_rdata, !got_d, got_d, rd);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        n_cmp++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== m_addr ||
            icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: got rd=%b wr=%b addr=%h iresp=%b dresp=%b, want 0 0 %h 0 0",
                     pmem_read, pmem_write, pmem_address, icache_resp, dcache_resp, m_addr);
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== '0 ||
            pmem_wdata !== '0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h iresp=%b dresp=%b, want all 0",
                     pmem_read, pmem_write, pmem_address, icache_resp, dcache_resp);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== '0 || pmem_wdata !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rd=%b wr=%b addr=%h, want 0 0 0",
                     pmem_read, pmem_write, pmem_address);
        end
    endtask

    task automatic test_icache_fill();
        logic g;
        logic [LINE_W-1:0] aa;
        aa = {(LINE_W / 32){32'hAAAA_AAAA}};
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, '0, 3, aa, g);
        n_cmp++;
        if (g !== 1'b0) begin
            n_fail++;
            $display("FAIL icache_fill_grant: got d=%b want d=0", g);
        end
    endtask

    task automatic test_alternate();
        logic g;
        logic exp_d;
        test_reset();
        exp_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b1, 1'b1, 1'b0, 32'h100 + 32'(k), 32'h200 + 32'(k), rand_line(),
                    $urandom_range(0, 2), rand_line(), g);
            n_cmp++;
            if (g !== exp_d) begin
                n_fail++;
                $display("FAIL alternate_%0d: grant d=%b want d=%b", k, g, exp_d);
            end
            exp_d = !exp_d;
        end
    endtask

    task automatic test_write_stable();
        logic g;
        logic [LINE_W-1:0] wd;
        wd = {(LINE_W / 32){32'h1234_5678}};
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1FE0, wd, 4, rand_line(), g);
        n_cmp++;
        if (pmem_wdata !== wd) begin
            n_fail++;
            $display("FAIL write_wdata_held: got %h want %h", pmem_wdata, wd);
        end
    endtask

    task automatic test_resp_idle();
        logic g;
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = rand_line();
        #1;
        n_cmp++;
        if (icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_resp: got iresp=%b dresp=%b want 0 0", icache_resp, dcache_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        n_cmp++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== m_addr) begin
            n_fail++;
            $display("FAIL idle_resp_state: got rd=%b wr=%b addr=%h want 0 0 %h",
                     pmem_read, pmem_write, pmem_address, m_addr);
        end
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0440, 32'h0, '0, 1, rand_line(), g);
    endtask

    task automatic test_reset_mid();
        logic g;
        @(negedge clk);
        icache_read = 1'b1; icache_address = 32'h0000_0880;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        pmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (pmem_read !== 1'b0 || icache_resp !== 1'b0 || pmem_address !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got rd=%b iresp=%b addr=%h want 0 0 0",
                     pmem_read, icache_resp, pmem_address);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pmem_resp = 1'b0;
        run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0A00, rand_line(), 1, rand_line(), g);
        n_cmp++;
        if (g !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_first_tie: grant d=%b want d=1", g);
        end
    endtask

    task automatic test_rw_both();
        logic g;
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0C40, rand_line(), 2, rand_line(), g);
    endtask

    task automatic test_random();
        logic g;
        logic ir, dr, dw;
        for (int k = 0; k < 40; k++) begin
            ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
            if (!ir && !dr && !dw) ir = 1'b1;
            run_txn(ir, dr, dw, $urandom, $urandom, rand_line(),
                    $urandom_range(0, 4), rand_line(), g);
        end
    endtask

    initial begin
        test_reset();
        test_icache_fill();
        test_alternate();
        test_write_stable();
        test_resp_idle();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
